// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential instructions from program memory into a
// small FIFO and discards in-flight data when a branch redirects the stream.
module fetch_prefetch_queue #(
    parameter int unsigned          PC_WIDTH   = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    output logic                     o_PgmReq,
    output logic [PC_WIDTH-1:0]      o_PgmAddr,
    input  logic                     i_PgmAck,
    input  logic [INST_WIDTH-1:0]    i_PgmInst,
    output logic                     o_Valid,
    output logic [INST_WIDTH-1:0]    o_Inst,
    output logic [PC_WIDTH-1:0]      o_PC,
    input  logic                     i_Ready,
    input  logic                     i_Redirect,
    input  logic [PC_WIDTH-1:0]      i_RedirectPC,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    state_e                 state_q;
    logic [PC_WIDTH-1:0]    fetch_pc_q;
    logic [PC_WIDTH-1:0]    discard_pc_q;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;

    logic [PC_WIDTH-1:0]    pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0]  inst_mem [DEPTH];

    logic push;
    logic pop;

    // Request is a pure decode of state and occupancy, so no input reaches it combinationally.
    assign o_PgmReq  = ((state_q == StFetch) && (count_q != CntW'(DEPTH))) ||
                       (state_q == StDiscard);
    assign o_PgmAddr = (state_q == StDiscard) ? discard_pc_q : fetch_pc_q;

    assign o_Valid = (count_q != '0);
    assign o_Count = count_q;
    assign o_Inst  = inst_mem[rd_ptr_q];
    assign o_PC    = pc_mem[rd_ptr_q];

    assign push = (state_q == StFetch) && o_PgmReq && i_PgmAck && !i_Redirect;
    assign pop  = o_Valid && i_Ready && !i_Redirect;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            discard_pc_q <= RESET_PC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    if (i_Redirect) fetch_pc_q <= i_RedirectPC;
                end
                StFetch: begin
                    if (i_Redirect) begin
                        fetch_pc_q <= i_RedirectPC;
                        // An unacked request must still complete on the bus; park it.
                        if (o_PgmReq && !i_PgmAck) begin
                            discard_pc_q <= fetch_pc_q;
                            state_q      <= StDiscard;
                        end
                    end else if (push) begin
                        fetch_pc_q <= fetch_pc_q + PC_WIDTH'(4);
                    end
                end
                StDiscard: begin
                    if (i_Redirect) begin
                        fetch_pc_q <= i_RedirectPC;
                    end else if (i_PgmAck) begin
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_Redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= i_PgmInst;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: stream, fill/stall, wait states, redirects, reset.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pgm_req;
    logic [31:0] pgm_addr;
    logic        pgm_ack = 1'b0;
    logic [31:0] pgm_inst;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns a tag derived from the address so the bench knows what data to expect.
    assign pgm_inst = pgm_addr ^ 32'hA5A5_0000;

    fetch_prefetch_queue #(
        .PC_WIDTH   (32),
        .INST_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h100)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .o_PgmReq     (pgm_req),
        .o_PgmAddr    (pgm_addr),
        .i_PgmAck     (pgm_ack),
        .i_PgmInst    (pgm_inst),
        .o_Valid      (valid),
        .o_Inst       (inst),
        .o_PC         (pc),
        .i_Ready      (ready),
        .i_Redirect   (redirect),
        .i_RedirectPC (redirect_pc),
        .o_Count      (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pgm_ack = 1'b0; ready = 1'b0; redirect = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (pgm_req !== 1'b0) begin errors++;
            $display("FAIL reset_req got %b want 0", pgm_req); end
        checks++; if (valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (count !== 3'd0) begin errors++;
            $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (pgm_addr !== 32'h100) begin errors++;
            $display("FAIL reset_addr got %h want 00000100", pgm_addr); end
    endtask

    task automatic test_stream();
        pgm_ack = 1'b1; ready = 1'b1; redirect = 1'b0;
        do_reset();
        checks++; if (pgm_req !== 1'b0) begin errors++;
            $display("FAIL stream_idle_req got %b want 0", pgm_req); end
        tick();
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h100) begin errors++;
            $display("FAIL stream_first_req got %b/%h want 1/00000100", pgm_req, pgm_addr); end
        checks++; if (valid !== 1'b0) begin errors++;
            $display("FAIL stream_not_yet_valid got %b want 0", valid); end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h100 + 32'(4 * k);
            tick();
            checks++;
            if (valid !== 1'b1 || pc !== exp_pc || inst !== (exp_pc ^ 32'hA5A5_0000) ||
                count !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d got v=%b pc=%h inst=%h cnt=%0d want v=1 pc=%h cnt=1",
                         k, valid, pc, inst, count, exp_pc);
            end
        end
    endtask

    task automatic test_fill_stall();
        pgm_ack = 1'b1; ready = 1'b0; redirect = 1'b0;
        do_reset();
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (count !== 3'(k)) begin errors++;
                $display("FAIL fill_count_%0d got %0d want %0d", k, count, k); end
        end
        checks++; if (pgm_req !== 1'b0) begin errors++;
            $display("FAIL full_req got %b want 0", pgm_req); end
        checks++; if (pc !== 32'h100) begin errors++;
            $display("FAIL full_head got %h want 00000100", pc); end
        // Ack stays high while no request is outstanding; it must not push.
        ready = 1'b1;
        tick();
        checks++; if (count !== 3'd3) begin errors++;
            $display("FAIL pop_count got %0d want 3", count); end
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h110) begin errors++;
            $display("FAIL reissue got %b/%h want 1/00000110", pgm_req, pgm_addr); end
        tick();
        checks++; if (count !== 3'd3 || pc !== 32'h108 || pgm_addr !== 32'h114) begin errors++;
            $display("FAIL push_pop_full1 got cnt=%0d pc=%h addr=%h want 3/00000108/00000114",
                     count, pc, pgm_addr); end
        ready = 1'b0;
        tick();
        checks++; if (count !== 3'd4 || pgm_req !== 1'b0) begin errors++;
            $display("FAIL refill got cnt=%0d req=%b want 4/0", count, pgm_req); end
    endtask

    task automatic test_wait_states();
        pgm_ack = 1'b0; ready = 1'b0; redirect = 1'b0;
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h100 || count !== 3'd0) begin
                errors++;
                $display("FAIL wait_hold_%0d got req=%b addr=%h cnt=%0d want 1/00000100/0",
                         k, pgm_req, pgm_addr, count); end
            tick();
        end
        pgm_ack = 1'b1;
        tick();
        pgm_ack = 1'b0;
        checks++; if (count !== 3'd1 || pc !== 32'h100 || inst !== 32'hA5A5_0100) begin errors++;
            $display("FAIL wait_push got cnt=%0d pc=%h inst=%h want 1/00000100/a5a50100",
                     count, pc, inst); end
        checks++; if (pgm_addr !== 32'h104) begin errors++;
            $display("FAIL wait_next_addr got %h want 00000104", pgm_addr); end
    endtask

    task automatic test_redirect_pending();
        pgm_ack = 1'b1; ready = 1'b0; redirect = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        pgm_ack = 1'b0;
        checks++; if (count !== 3'd2 || pgm_addr !== 32'h108) begin errors++;
            $display("FAIL pend_setup got cnt=%0d addr=%h want 2/00000108", count, pgm_addr); end
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h108 || valid !== 1'b0 ||
                      count !== 3'd0) begin errors++;
            $display("FAIL discard_enter got req=%b addr=%h v=%b cnt=%0d want 1/00000108/0/0",
                     pgm_req, pgm_addr, valid, count); end
        tick();
        tick();
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h108) begin errors++;
            $display("FAIL discard_hold got %b/%h want 1/00000108", pgm_req, pgm_addr); end
        pgm_ack = 1'b1;
        tick();
        checks++; if (valid !== 1'b0 || pgm_req !== 1'b1 || pgm_addr !== 32'h200) begin errors++;
            $display("FAIL discard_drop got v=%b req=%b addr=%h want 0/1/00000200",
                     valid, pgm_req, pgm_addr); end
        tick();
        pgm_ack = 1'b0;
        checks++; if (valid !== 1'b1 || pc !== 32'h200 || inst !== 32'hA5A5_0200) begin errors++;
            $display("FAIL redirect_data got v=%b pc=%h inst=%h want 1/00000200/a5a50200",
                     valid, pc, inst); end
    endtask

    task automatic test_redirect_push_pop();
        pgm_ack = 1'b1; ready = 1'b0; redirect = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        checks++; if (count !== 3'd3 || pgm_req !== 1'b1) begin errors++;
            $display("FAIL rpp_setup got cnt=%0d req=%b want 3/1", count, pgm_req); end
        ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; ready = 1'b0; pgm_ack = 1'b0;
        checks++; if (count !== 3'd0 || valid !== 1'b0) begin errors++;
            $display("FAIL rpp_flush got cnt=%0d v=%b want 0/0", count, valid); end
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h40) begin errors++;
            $display("FAIL rpp_next got %b/%h want 1/00000040", pgm_req, pgm_addr); end
        pgm_ack = 1'b1;
        tick();
        pgm_ack = 1'b0;
        checks++; if (count !== 3'd1 || pc !== 32'h40) begin errors++;
            $display("FAIL rpp_push got cnt=%0d pc=%h want 1/00000040", count, pc); end
    endtask

    task automatic test_reset_discard();
        pgm_ack = 1'b1; ready = 1'b0; redirect = 1'b0;
        do_reset();
        tick();
        tick();
        pgm_ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h104) begin errors++;
            $display("FAIL rd_setup got %b/%h want 1/00000104", pgm_req, pgm_addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pgm_req !== 1'b0 || pgm_addr !== 32'h100 || count !== 3'd0) begin errors++;
            $display("FAIL rd_async got req=%b addr=%h cnt=%0d want 0/00000100/0",
                     pgm_req, pgm_addr, count); end
        tick();
        rst = 1'b0;
        checks++; if (pgm_req !== 1'b0) begin errors++;
            $display("FAIL rd_idle got %b want 0", pgm_req); end
        tick();
        checks++; if (pgm_req !== 1'b1 || pgm_addr !== 32'h100 || valid !== 1'b0) begin errors++;
            $display("FAIL rd_first_req got req=%b addr=%h v=%b want 1/00000100/0",
                     pgm_req, pgm_addr, valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_wait_states();
        test_redirect_pending();
        test_redirect_push_pop();
        test_reset_discard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, meaning program-address width in bits.
REQ-002 The block SHALL have parameter INST_WIDTH, default 32, meaning instruction width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2 or more.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 The block SHALL have port i_Clock, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port i_Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port o_PgmReq, output, 1 bit: program memory request.
REQ-008 The block SHALL have port o_PgmAddr, output, PC_WIDTH bits: request address.
REQ-009 The block SHALL have port i_PgmAck, input, 1 bit: request accepted; i_PgmInst is valid in the same cycle.
REQ-010 The block SHALL have port i_PgmInst, input, INST_WIDTH bits: fetched instruction.
REQ-011 The block SHALL have port o_Valid, output, 1 bit: the queue head is valid.
REQ-012 The block SHALL have port o_Inst, output, INST_WIDTH bits: head instruction.
REQ-013 The block SHALL have port o_PC, output, PC_WIDTH bits: head instruction address.
REQ-014 The block SHALL have port i_Ready, input, 1 bit: the decode stage consumes the head.
REQ-015 The block SHALL have port i_Redirect, input, 1 bit: branch or jump redirect.
REQ-016 The block SHALL have port i_RedirectPC, input, PC_WIDTH bits: redirect target.
REQ-017 The block SHALL have port o_Count, output, clog2(DEPTH)+1 bits: occupied entries.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, FETCH and DISCARD.
REQ-019 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-020 o_PgmReq SHALL be 1 when (state FETCH and o_Count < DEPTH) or state is DISCARD; otherwise it SHALL be 0.
REQ-021 o_PgmReq SHALL be decoded from registers only, with no combinational path from any input.
REQ-022 o_PgmAddr SHALL equal the internal fetch PC in FETCH and the latched discard address in DISCARD.
REQ-023 o_PgmReq and o_PgmAddr SHALL be held stable from assertion until the cycle i_PgmAck=1, except when a redirect occurs in FETCH.
REQ-024 Push: in FETCH with o_PgmReq=1 and i_PgmAck=1 and no redirect, {fetch PC, i_PgmInst} SHALL be written at the write pointer, and the fetch PC SHALL advance by 4, mod 2^PC_WIDTH.
REQ-025 Consecutive acks SHALL give one fetch per cycle; a zero-wait memory therefore fills the queue at one entry per cycle.
REQ-026 o_Valid SHALL equal (o_Count != 0).
REQ-027 o_Inst and o_PC SHALL present the head entry directly, with zero latency from the push edge to visibility on the following cycle.
REQ-028 Pop: when o_Valid=1 and i_Ready=1 with no redirect, the read pointer SHALL advance.
REQ-029 When push and pop occur in the same cycle, o_Count SHALL be unchanged; this applies also when the queue is full-minus-one.
REQ-030 When the queue is full (o_Count=DEPTH) in FETCH, no request SHALL be issued; requests SHALL resume the cycle after a pop.
REQ-031 Pointers SHALL wrap modulo DEPTH.
REQ-032 i_Redirect SHALL have priority over push and pop in the same cycle.
REQ-033 On redirect, the next-edge values SHALL be o_Count=0 and pointers=0; any pop or push in that cycle SHALL be ignored.
REQ-034 On redirect in FETCH with o_PgmReq=1 and i_PgmAck=0, the block SHALL latch the old address as the discard address, set fetch PC=i_RedirectPC and go to DISCARD.
REQ-035 On redirect otherwise (no pending request, or the request was acked that cycle), the block SHALL set fetch PC=i_RedirectPC and stay in or enter FETCH, and acked data SHALL be dropped.
REQ-036 In DISCARD, the block SHALL keep requesting the discard address; on i_PgmAck it SHALL drop the data and go to FETCH.
REQ-037 A further redirect during DISCARD SHALL overwrite fetch PC only, and the state SHALL stay DISCARD.
REQ-038 i_PgmAck while o_PgmReq=0 SHALL be ignored.

Reset
REQ-039 While i_Reset=1, the block SHALL hold: state IDLE, fetch PC=RESET_PC, o_Count=0, pointers=0, o_PgmReq=0, o_Valid=0, o_PgmAddr=RESET_PC.
REQ-040 Assertion of i_Reset mid-transaction SHALL abandon the pending request immediately, and no queue content SHALL survive.
REQ-041 The first request after reset release SHALL be at the second rising edge (one IDLE cycle).
REQ-042 Queue storage SHALL need no reset; validity SHALL derive only from o_Count.

Verification
REQ-043 Zero-wait stream: with DEPTH=4, RESET_PC=0x100, i_PgmAck=1 and i_Ready=1 -> o_PC sequence 0x100, 0x104, 0x108..., one per cycle after 2 cycles of fill.
REQ-044 Fill and stall: with i_Ready=0 and ack always 1 -> o_Count reaches 4 and o_PgmReq drops; one pop -> a request reissues next cycle at 0x110.
REQ-045 Wait states: ack 3 cycles after request -> o_PgmAddr stable for 3 cycles, and the pushed PC is correct.
REQ-046 Redirect while pending: request 0x108 unacked, redirect to 0x200 -> DISCARD holds 0x108 until ack, its data is dropped, then a request at 0x200 follows, and o_Valid=0 until 0x200 data arrives.
REQ-047 Redirect with simultaneous push and pop: o_Count=3, ack=1, i_Ready=1, redirect to 0x40 -> next cycle o_Count=0, next fetch 0x40.
REQ-048 Reset mid-DISCARD: assert i_Reset -> o_PgmReq=0 asynchronously; after release, one IDLE cycle, then a request at RESET_PC.
